rr_decoder_arbiter: RTL
=======================

Name: rr_decoder_arbiter

Overview:
- Round-robin arbiter sharing one resource among 2**n requesters.
- Registers an n-bit winner index and drives the one-hot select through a generic decoder stage: index plus enable to a one-hot vector, same bit ordering as the decoder, so `gnt[0]` is index 0.
- Sequences ownership: grant, hold, release, then advance priority.
- Includes a watchdog that force-releases a stuck owner.

Parameters:
- n, 2, index width; requester count is 2**n.
- TMO, 8, maximum grant hold in cycles before forced release; must be ≥ 2.
- TW, 4, width of the hold counter; must satisfy 2**TW > TMO.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  2**n  request vector; `req[i]` is requester i; level-sensitive.
- done  input  1  single-cycle release from the current owner; ignored unless in GRANT.
- gnt_idx  output  n  registered index of the current or last owner.
- gnt_en  output  1  registered; high while a grant is active.
- gnt  output  [0:2**n-1]  one-hot decode of `gnt_idx` gated by `gnt_en`; all zero when `gnt_en` = 0.
- busy  output  1  equal to `gnt_en`.
- tmo  output  1  registered one-cycle pulse on forced release.

Behaviour:
- Async reset (rst_n = 0), effective immediately regardless of clk, including mid-grant:
  - state = IDLE, ptr = 0, gnt_idx = 0, gnt_en = 0, gnt = all 0, busy = 0, tmo = 0, hold counter = 0.
- Internal: 2-state FSM (IDLE, GRANT), n-bit priority pointer ptr, TW-bit hold counter cnt.
- IDLE:
  - If req = 0, stay.
  - Otherwise winner = first i with `req[i]` = 1, searching ptr, ptr+1, …, wrapping mod 2**n.
  - Next edge: gnt_idx = winner, gnt_en = 1, cnt = 1, state = GRANT.
  - Latency: request sampled at edge k, grant visible after edge k.
- GRANT release conditions, evaluated each edge in this priority order:
  1. `done` = 1.
  2. `req[gnt_idx]` = 0 (owner dropped its request).
  3. cnt = TMO (watchdog).
- On any release at an edge:
  - gnt_en = 0, state = IDLE, ptr = gnt_idx + 1 mod 2**n (wrap from 2**n−1 to 0), cnt = 0.
  - gnt_idx holds its value.
  - tmo = 1 for one cycle only if release cause 3 alone applied; done or drop on the same edge as the watchdog suppresses tmo.
- No release: cnt increments, saturating at TMO; grant held.
- Minimum one IDLE cycle between consecutive grants; there is no back-to-back handoff.
- A grant is never changed mid-ownership by a higher-priority request.
- Simultaneous `done` and owner drop count as one release; ptr advances once.
- `done` in IDLE: ignored, no state change.
- gnt is derived combinationally from the gnt_idx/gnt_en registers only; there is no path from req to gnt.
- Invariant: at most one gnt bit is high; popcount(gnt) = gnt_en.
- Fairness: with all requests held high, each requester is granted once per 2**n grants.

Test Plan:
- Reset mid-grant: grant idx 2 active, pulse rst_n low between edges -> gnt = 0000, gnt_en = 0, tmo = 0 immediately; after release, req = 1111 grants idx 0 (ptr reset).
- Single request: req = 0100 from IDLE -> after next edge gnt_idx = 2, gnt = 0010 (bits [0:3]), busy = 1; done pulse -> next edge gnt = 0000, then req = 1111 grants idx 3 (ptr = 3).
- Rotation: req = 1111 held, done pulsed one cycle after each grant -> grant order 0, 1, 2, 3, 0, one IDLE cycle between each, never two gnt bits high.
- Watchdog (TMO = 8): req = 0010 held, no done -> gnt_idx = 1 for 8 cycles, then gnt_en = 0 with tmo = 1 for exactly one cycle; next grant is idx 1 again (only requester), and ptr = 2 before it.
- Owner drop and collision: owner idx 3 drops req on the same cycle done = 1 -> single release, ptr wraps to 0, tmo = 0; done in IDLE -> no output change.
- Pointer skip: ptr = 1, req = 1001 -> grant idx 3 (search 1, 2, 3), then ptr = 0 and next grant idx 0.

Source files
------------

// File: rtl/rr_decoder_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_decoder_arbiter : round-robin arbiter with one-hot decoded grant
// Revision: 1.0
// ------------------------------------------------------------------
module rr_decoder_arbiter #(
  parameter int N   = 2,
  parameter int TMO = 8,
  parameter int TW  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2**N-1:0]   req,
  input  logic              done,
  output logic [N-1:0]      gnt_idx,
  output logic              gnt_en,
  output logic [0:2**N-1]   gnt,
  output logic              busy,
  output logic              tmo
);

  localparam int NR = 2**N;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]    r_state, w_state_nxt;
  logic [N-1:0]  r_ptr, w_ptr_nxt;
  logic [N-1:0]  r_idx, w_idx_nxt;
  logic [TW-1:0] r_cnt, w_cnt_nxt;
  logic          r_tmo, w_tmo_nxt;
  logic [N-1:0]  w_winner;
  logic          w_any, w_drop, w_wd, w_release;

  // Scan from the highest offset down so the offset closest to ptr wins.
  always_comb begin
    w_winner = r_ptr;
    w_any    = |req;
    for (int k = NR - 1; k >= 0; k--) begin
      if (req[r_ptr + N'(k)]) w_winner = r_ptr + N'(k);
    end
  end

  assign w_drop    = ~req[r_idx];
  assign w_wd      = (r_cnt == TW'(TMO));
  assign w_release = done | w_drop | w_wd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_tmo_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_GRANT;
          w_idx_nxt   = w_winner;
          w_cnt_nxt   = TW'(1);
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = r_idx + N'(1);
          w_cnt_nxt   = '0;
          // Watchdog pulse only when no voluntary release shares the edge.
          w_tmo_nxt   = w_wd & ~done & ~w_drop;
        end else if (!w_wd) begin
          w_cnt_nxt = r_cnt + TW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_en  = (r_state == S_GRANT);
    busy    = gnt_en;
    gnt_idx = r_idx;
    tmo     = r_tmo;
  end

  generate
    for (genvar i = 0; i < NR; i++) begin : g_dec
      assign gnt[i] = gnt_en & (r_idx == N'(i));
    end
  endgenerate

endmodule
`default_nettype wire
